// File: rtl/tmr_req_arb.sv
// tmr_req_arb: round-robin scheduler that shares one prescaled timer tick among
// several timeout requesters. One requester holds the grant at a time and its
// timeout is counted down on the shared tick by a single down-counter.
module tmr_req_arb #(
   parameter int unsigned REQ_NUM   = 4,
   parameter int unsigned CNT_WIDTH = 32,
   parameter int unsigned ID_WIDTH  = $clog2(REQ_NUM)
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         tick_i,
   input  logic [REQ_NUM-1:0]           req_i,
   input  logic [REQ_NUM*CNT_WIDTH-1:0] val_i,
   output logic [REQ_NUM-1:0]           gnt_o,
   output logic [ID_WIDTH-1:0]          gnt_id_o,
   output logic [REQ_NUM-1:0]           done_o,
   output logic                         busy_o,
   output logic [CNT_WIDTH-1:0]         cnt_o
);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e               state_q;
   logic [ID_WIDTH-1:0]  ptr_q;
   logic [REQ_NUM-1:0]   gnt_q;
   logic [ID_WIDTH-1:0]  gnt_id_q;
   logic [REQ_NUM-1:0]   done_q;
   logic                 busy_q;
   logic [CNT_WIDTH-1:0] cnt_q;

   // Round-robin arbitration results, only consumed in IDLE.
   logic [CNT_WIDTH-1:0] val_arr [REQ_NUM];
   logic [ID_WIDTH-1:0]  scan_idx;
   logic                 win_found;
   logic [ID_WIDTH-1:0]  win_id;
   logic [REQ_NUM-1:0]   win_oh;
   logic [CNT_WIDTH-1:0] win_val;
   logic [ID_WIDTH-1:0]  win_nxt;

   // Unpack the flat timeout bus into one entry per requester.
   always_comb begin
      for (int unsigned k = 0; k < REQ_NUM; k++) begin
         val_arr[k] = val_i[k*CNT_WIDTH +: CNT_WIDTH];
      end
   end

   // Scan requests starting at ptr, wrapping past REQ_NUM-1; first set bit wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
         scan_idx = ID_WIDTH'((32'(ptr_q) + i) % REQ_NUM);
         if (!win_found && req_i[scan_idx]) begin
            win_found = 1'b1;
            win_id    = scan_idx;
         end
      end
      win_oh         = '0;
      win_oh[win_id] = win_found;
      win_val        = val_arr[win_id];
      // Next search starts just past the winner so it goes to the back of the line.
      win_nxt        = (32'(win_id) == REQ_NUM - 1) ? '0 : win_id + ID_WIDTH'(1);
   end

   // Scheduler FSM; every output is a register updated here.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         done_q <= '0;
         unique case (state_q)
            StIdle: begin
               // Ticks are ignored here; a tick in the grant cycle is not counted.
               if (win_found) begin
                  state_q  <= StRun;
                  gnt_q    <= win_oh;
                  gnt_id_q <= win_id;
                  cnt_q    <= win_val;
                  ptr_q    <= win_nxt;
                  busy_q   <= 1'b1;
               end
            end
            StRun: begin
               // Abort beats a coincident tick and never produces done.
               if (!req_i[gnt_id_q]) begin
                  state_q <= StIdle;
                  gnt_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (tick_i) begin
                  // Values 0 and 1 both expire on the first tick; never wrap below 0.
                  if (cnt_q <= CNT_WIDTH'(1)) begin
                     state_q <= StDone;
                     done_q  <= gnt_q;
                     gnt_q   <= '0;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q - CNT_WIDTH'(1);
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               gnt_q   <= '0;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_o    = gnt_q;
   assign gnt_id_o = gnt_id_q;
   assign done_o   = done_q;
   assign busy_o   = busy_q;
   assign cnt_o    = cnt_q;

endmodule

// File: tb/tb_tmr_req_arb.sv
// Directed bench for tmr_req_arb: single grant, 0/1 timeouts, round-robin order,
// abort, asynchronous reset mid-RUN and back-to-back regrant of a lone requester.
module tb_tmr_req_arb;

   localparam int unsigned REQ_NUM   = 4;
   localparam int unsigned CNT_WIDTH = 32;
   localparam int unsigned ID_WIDTH  = 2;

   logic                         clk = 1'b0;
   logic                         rst_n = 1'b0;
   logic                         tick = 1'b0;
   logic [REQ_NUM-1:0]           req = '0;
   logic [REQ_NUM*CNT_WIDTH-1:0] val = '0;
   logic [REQ_NUM-1:0]           gnt;
   logic [ID_WIDTH-1:0]          gnt_id;
   logic [REQ_NUM-1:0]           done;
   logic                         busy;
   logic [CNT_WIDTH-1:0]         cnt;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   tmr_req_arb #(
      .REQ_NUM   (REQ_NUM),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .tick_i   (tick),
      .req_i    (req),
      .val_i    (val),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id),
      .done_o   (done),
      .busy_o   (busy),
      .cnt_o    (cnt)
   );

   always #5 clk = ~clk;

   // Advance one cycle; leaves us 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic do_tick();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   task automatic set_val(input int k, input logic [31:0] v);
      val[k*CNT_WIDTH +: CNT_WIDTH] = v;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".gnt"}, 64'(gnt), 64'h0);
      chk({tag, ".done"}, 64'(done), 64'h0);
      chk({tag, ".busy"}, 64'(busy), 64'h0);
      chk({tag, ".cnt"}, 64'(cnt), 64'h0);
   endtask

   int rr_exp [6] = '{0, 1, 3, 0, 1, 3};
   int d1;
   int d2;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      idle(2);
      chk_idle("reset");
      chk("reset.gnt_id", 64'(gnt_id), 64'h0);
      rst_n = 1'b1;
      cyc();

      // Single request, val=3, tick every 4 cycles
      set_val(0, 3);
      req = 4'b0001;
      cyc();
      chk("single.gnt", 64'(gnt), 64'h1);
      chk("single.busy", 64'(busy), 64'h1);
      chk("single.cnt3", 64'(cnt), 64'd3);
      chk("single.id", 64'(gnt_id), 64'h0);
      idle(3); do_tick();
      chk("single.cnt2", 64'(cnt), 64'd2);
      idle(3); do_tick();
      chk("single.cnt1", 64'(cnt), 64'd1);
      chk("single.nodone", 64'(done), 64'h0);
      idle(3); do_tick();
      chk("single.done", 64'(done), 64'h1);
      chk("single.gnt0", 64'(gnt), 64'h0);
      chk("single.busy_done", 64'(busy), 64'h1);
      req = '0;
      cyc();
      chk_idle("single.after");
      chk("single.id_hold", 64'(gnt_id), 64'h0);

      // Zero timeout, tick in the grant-decision cycle is ignored
      set_val(0, 0);
      req  = 4'b0001;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("zero.gnt", 64'(gnt), 64'h1);
      chk("zero.cnt", 64'(cnt), 64'd0);
      idle(2);
      chk("zero.nodone", 64'(done), 64'h0);
      chk("zero.still_gnt", 64'(gnt), 64'h1);
      do_tick();
      chk("zero.done", 64'(done), 64'h1);
      req = '0;
      cyc();

      // One timeout
      set_val(0, 1);
      req  = 4'b0001;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("one.cnt", 64'(cnt), 64'd1);
      idle(1);
      chk("one.nodone", 64'(done), 64'h0);
      do_tick();
      chk("one.done", 64'(done), 64'h1);
      req = '0;
      cyc();
      chk_idle("one.after");

      // Round-robin with ptr reset to 0
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) set_val(k, 1);
      req = 4'b1011;
      cyc();
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("rr%0d.gnt", i), 64'(gnt), 64'(4'b0001 << rr_exp[i]));
         chk($sformatf("rr%0d.id", i), 64'(gnt_id), 64'(rr_exp[i]));
         do_tick();
         chk($sformatf("rr%0d.done", i), 64'(done), 64'(4'b0001 << rr_exp[i]));
         if (i == 5) req = '0;
         cyc();
         chk($sformatf("rr%0d.gap", i), 64'(gnt), 64'h0);
         cyc();
      end
      chk_idle("rr.end");

      // Abort with coincident tick; pending req0 granted one cycle later
      set_val(2, 10);
      req = 4'b0100;
      cyc();
      chk("abort.gnt", 64'(gnt), 64'h4);
      chk("abort.cnt10", 64'(cnt), 64'd10);
      do_tick();
      do_tick();
      chk("abort.cnt8", 64'(cnt), 64'd8);
      req  = 4'b0001;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk_idle("abort.drop");
      cyc();
      chk("abort.regnt", 64'(gnt), 64'h1);
      chk("abort.regnt_id", 64'(gnt_id), 64'h0);
      req = '0;
      cyc();
      chk_idle("abort.after");

      // Asynchronous reset mid-RUN
      set_val(0, 5);
      set_val(1, 7);
      req = 4'b0001;
      cyc();
      chk("rst.cnt5", 64'(cnt), 64'd5);
      chk("rst.gnt", 64'(gnt), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle("rst.async");
      cyc();
      rst_n = 1'b1;
      req   = 4'b0011;
      cyc();
      chk("rst.ptr0_gnt", 64'(gnt), 64'h1);
      chk("rst.ptr0_id", 64'(gnt_id), 64'h0);
      chk("rst.ptr0_cnt", 64'(cnt), 64'd5);
      req = '0;
      cyc();

      // Back-to-back single requester
      set_val(0, 2);
      req = 4'b0001;
      cyc();
      chk("b2b.cnt2", 64'(cnt), 64'd2);
      do_tick();
      chk("b2b.cnt1", 64'(cnt), 64'd1);
      do_tick();
      chk("b2b.done1", 64'(done), 64'h1);
      d1 = cyc_n;
      cyc();
      chk("b2b.idle_gnt", 64'(gnt), 64'h0);
      chk("b2b.idle_busy", 64'(busy), 64'h0);
      cyc();
      chk("b2b.regnt", 64'(gnt), 64'h1);
      chk("b2b.regnt_cnt", 64'(cnt), 64'd2);
      do_tick();
      chk("b2b.nodone", 64'(done), 64'h0);
      do_tick();
      chk("b2b.done2", 64'(done), 64'h1);
      d2 = cyc_n;
      chk("b2b.spacing", 64'(d2 - d1), 64'd4);
      req = '0;
      cyc();
      cyc();
      chk_idle("b2b.end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
